// File: rtl/uart_tx_top.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_top
//  Purpose  : 16550A-style UART transmitter; serializes start, 5-8 data bits,
//             optional parity and 1/1.5/2 stop bits on a 16x baud tick.
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_top (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_pulse,
    input  logic       pen,
    input  logic       thre,
    input  logic       stb,
    input  logic       sticky_parity,
    input  logic       eps,
    input  logic       set_break,
    input  logic [7:0] din,
    input  logic [1:0] wls,
    output logic       pop,
    output logic       sreg_empty,
    output logic       tx
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam logic [4:0] BIT_LAST    = 5'd15;
    localparam logic [4:0] STOP15_LAST = 5'd23;
    localparam logic [4:0] STOP2_LAST  = 5'd31;

    logic [2:0] r_state;
    logic [4:0] r_tick;
    logic [2:0] r_bit;
    logic [7:0] r_shift;
    logic [7:0] r_data;
    logic [1:0] r_wls;
    logic       r_pen;
    logic       r_eps;
    logic       r_sp;
    logic       r_stb;
    logic       r_pop;
    logic       r_empty;
    logic       r_tx;

    logic [2:0] w_state_nx;
    logic [4:0] w_tick_nx;
    logic [2:0] w_bit_nx;
    logic [7:0] w_shift_nx;
    logic       w_empty_nx;
    logic       w_load;
    logic [4:0] w_period_last;
    logic [2:0] w_bit_last;
    logic [7:0] w_mask;
    logic       w_parity;
    logic       w_line_nx;

    // Frame configuration is captured at load so mid-frame LCR writes cannot corrupt it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_tick  <= 5'd0;
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
            r_data  <= 8'd0;
            r_wls   <= 2'd0;
            r_pen   <= 1'b0;
            r_eps   <= 1'b0;
            r_sp    <= 1'b0;
            r_stb   <= 1'b0;
            r_pop   <= 1'b0;
            r_empty <= 1'b1;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nx;
            r_tick  <= w_tick_nx;
            r_bit   <= w_bit_nx;
            r_shift <= w_shift_nx;
            r_pop   <= w_load;
            r_empty <= w_empty_nx;
            r_tx    <= set_break ? 1'b0 : w_line_nx;
            if (w_load) begin
                r_data <= din;
                r_wls  <= wls;
                r_pen  <= pen;
                r_eps  <= eps;
                r_sp   <= sticky_parity;
                r_stb  <= stb;
            end
        end
    end

    always_comb begin
        w_period_last = BIT_LAST;
        if (r_state == S_STOP && r_stb) begin
            w_period_last = (r_wls == 2'b00) ? STOP15_LAST : STOP2_LAST;
        end
    end

    assign w_bit_last = {1'b0, r_wls} + 3'd4;

    always_comb begin
        w_state_nx = r_state;
        w_tick_nx  = r_tick;
        w_bit_nx   = r_bit;
        w_shift_nx = r_shift;
        w_empty_nx = r_empty;
        w_load     = 1'b0;
        if (baud_pulse) begin
            case (r_state)
                S_IDLE: begin
                    w_load = !thre;
                end
                S_START: begin
                    if (r_tick == w_period_last) begin
                        w_state_nx = S_DATA;
                        w_tick_nx  = 5'd0;
                    end else begin
                        w_tick_nx = r_tick + 5'd1;
                    end
                end
                S_DATA: begin
                    if (r_tick == w_period_last) begin
                        w_tick_nx = 5'd0;
                        if (r_bit == w_bit_last) begin
                            w_state_nx = r_pen ? S_PARITY : S_STOP;
                            w_bit_nx   = 3'd0;
                        end else begin
                            w_bit_nx   = r_bit + 3'd1;
                            w_shift_nx = {1'b0, r_shift[7:1]};
                        end
                    end else begin
                        w_tick_nx = r_tick + 5'd1;
                    end
                end
                S_PARITY: begin
                    if (r_tick == w_period_last) begin
                        w_state_nx = S_STOP;
                        w_tick_nx  = 5'd0;
                    end else begin
                        w_tick_nx = r_tick + 5'd1;
                    end
                end
                S_STOP: begin
                    if (r_tick == w_period_last) begin
                        w_tick_nx = 5'd0;
                        if (!thre) begin
                            w_load = 1'b1;
                        end else begin
                            w_state_nx = S_IDLE;
                            w_empty_nx = 1'b1;
                        end
                    end else begin
                        w_tick_nx = r_tick + 5'd1;
                    end
                end
                default: begin
                    w_state_nx = S_IDLE;
                    w_tick_nx  = 5'd0;
                    w_empty_nx = 1'b1;
                end
            endcase
        end
        if (w_load) begin
            w_state_nx = S_START;
            w_tick_nx  = 5'd0;
            w_bit_nx   = 3'd0;
            w_shift_nx = din;
            w_empty_nx = 1'b0;
        end
    end

    always_comb begin
        case (r_wls)
            2'b00:   w_mask = 8'h1F;
            2'b01:   w_mask = 8'h3F;
            2'b10:   w_mask = 8'h7F;
            default: w_mask = 8'hFF;
        endcase
    end

    assign w_parity = r_sp ? ~r_eps
                           : (r_eps ? ^(r_data & w_mask) : ~^(r_data & w_mask));

    // Line level is derived from the next state so tx changes on the same edge as the state
    always_comb begin
        w_line_nx = 1'b1;
        case (w_state_nx)
            S_START:  w_line_nx = 1'b0;
            S_DATA:   w_line_nx = w_shift_nx[0];
            S_PARITY: w_line_nx = w_parity;
            default:  w_line_nx = 1'b1;
        endcase
    end

    assign pop        = r_pop;
    assign sreg_empty = r_empty;
    assign tx         = r_tx;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_top.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_top
//  Purpose  : Self-checking bench for uart_tx_top against a frame-level model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_top;

    typedef struct packed {
        logic [7:0] din;
        logic [1:0] wls;
        logic       pen;
        logic       eps;
        logic       sp;
        logic       stb;
    } cfg_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       baud_pulse = 1'b0;
    logic       pen = 1'b0;
    logic       thre = 1'b1;
    logic       stb = 1'b0;
    logic       sticky_parity = 1'b0;
    logic       eps = 1'b0;
    logic       set_break = 1'b0;
    logic [7:0] din = 8'h00;
    logic [1:0] wls = 2'b00;
    logic       pop;
    logic       sreg_empty;
    logic       tx;

    int passes = 0;
    int fails  = 0;
    int total  = 0;
    int pop_cnt = 0;
    int bdiv = 6;
    int bcnt = 0;

    cfg_t cfgq[$];
    logic bits_q[$];
    int   dur_q[$];

    uart_tx_top dut (
        .clk           (clk),
        .rst           (rst),
        .baud_pulse    (baud_pulse),
        .pen           (pen),
        .thre          (thre),
        .stb           (stb),
        .sticky_parity (sticky_parity),
        .eps           (eps),
        .set_break     (set_break),
        .din           (din),
        .wls           (wls),
        .pop           (pop),
        .sreg_empty    (sreg_empty),
        .tx            (tx)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(negedge clk);
        if (bcnt >= bdiv - 1) begin
            baud_pulse = 1'b1;
            bcnt = 0;
        end else begin
            baud_pulse = 1'b0;
            bcnt++;
        end
    end

    always @(posedge clk) if (pop === 1'b1) pop_cnt <= pop_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (baud_pulse !== 1'b1) @(posedge clk);
        end
        #1;
    endtask

    function automatic cfg_t rand_cfg();
        cfg_t c;
        c.din = 8'($urandom);
        c.wls = 2'($urandom);
        c.pen = 1'($urandom);
        c.eps = 1'($urandom);
        c.sp  = 1'($urandom);
        c.stb = 1'($urandom);
        return c;
    endfunction

    task automatic drive_cfg(input cfg_t c);
        din = c.din; wls = c.wls; pen = c.pen;
        eps = c.eps; sticky_parity = c.sp; stb = c.stb;
    endtask

    // Expected line as (level, duration in ticks) pairs, straight from the frame rules
    task automatic build_frame(input cfg_t c);
        int nbits;
        int ones;
        bits_q.delete();
        dur_q.delete();
        nbits = 5 + int'(c.wls);
        ones = 0;
        bits_q.push_back(1'b0); dur_q.push_back(16);
        for (int i = 0; i < nbits; i++) begin
            bits_q.push_back(c.din[i]);
            dur_q.push_back(16);
            ones += int'(c.din[i]);
        end
        if (c.pen) begin
            if (c.sp)       bits_q.push_back(!c.eps);
            else if (c.eps) bits_q.push_back(ones % 2 == 1);
            else            bits_q.push_back(ones % 2 == 0);
            dur_q.push_back(16);
        end
        bits_q.push_back(1'b1);
        dur_q.push_back(c.stb ? ((c.wls == 2'b00) ? 24 : 32) : 16);
    endtask

    task automatic wait_pop(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (pop === 1'b1) break;
        end
        chk("first_pop", {31'd0, pop}, 32'd1);
    endtask

    // Sends every frame queued in cfgq back-to-back; break is applied during bit brk of frame 0
    task automatic do_frames(input int brk);
        int n;
        int base;
        int d;
        base = pop_cnt;
        n = cfgq.size();
        @(negedge clk);
        drive_cfg(cfgq[0]);
        thre = 1'b0;
        wait_pop(200);
        chk("start_tx", {31'd0, tx}, 32'd0);
        for (int k = 0; k < n; k++) begin
            build_frame(cfgq[k]);
            if (k < n - 1) begin
                drive_cfg(cfgq[k + 1]);
                thre = 1'b0;
            end else begin
                drive_cfg(rand_cfg());
                thre = 1'b1;
            end
            for (int j = 0; j < bits_q.size(); j++) begin
                d = dur_q[j];
                if (k == 0 && j == brk) begin
                    set_break = 1'b1;
                    wait_ticks(d / 2);
                    chk("break_tx", {31'd0, tx}, 32'd0);
                    set_break = 1'b0;
                    wait_ticks(1);
                    chk("post_break_tx", {31'd0, tx}, {31'd0, bits_q[j]});
                    wait_ticks(d - d / 2 - 1);
                end else begin
                    wait_ticks(d / 2);
                    chk($sformatf("f%0d_bit%0d", k, j), {31'd0, tx}, {31'd0, bits_q[j]});
                    if (j == 0) chk("busy_empty", {31'd0, sreg_empty}, 32'd0);
                    wait_ticks(d - d / 2);
                end
            end
            if (k < n - 1) begin
                chk("b2b_pop", {31'd0, pop}, 32'd1);
                chk("b2b_start", {31'd0, tx}, 32'd0);
            end else begin
                chk("end_pop", {31'd0, pop}, 32'd0);
                chk("end_empty", {31'd0, sreg_empty}, 32'd1);
                chk("end_tx", {31'd0, tx}, 32'd1);
            end
        end
        chk("pop_count", pop_cnt - base, n);
        cfgq.delete();
    endtask

    initial begin
        cfg_t c;
        int base;

        // reset and quiet idle
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("rst_tx", {31'd0, tx}, 32'd1);
            chk("rst_pop", {31'd0, pop}, 32'd0);
            chk("rst_empty", {31'd0, sreg_empty}, 32'd1);
        end
        @(negedge clk) rst = 1'b1;
        wait_ticks(20);
        chk("idle_tx", {31'd0, tx}, 32'd1);
        chk("idle_pops", pop_cnt, 0);

        // 8E2 followed back-to-back by 8O1
        bdiv = 6;
        cfgq.push_back('{din: 8'h13, wls: 2'b11, pen: 1'b1, eps: 1'b1, sp: 1'b0, stb: 1'b1});
        cfgq.push_back('{din: 8'h13, wls: 2'b11, pen: 1'b1, eps: 1'b0, sp: 1'b0, stb: 1'b0});
        do_frames(-1);

        // 5-bit word with 1.5 stop bits
        cfgq.push_back('{din: 8'hFF, wls: 2'b00, pen: 1'b0, eps: 1'b0, sp: 1'b0, stb: 1'b1});
        do_frames(-1);

        // stick parity both polarities
        bdiv = 2;
        c = rand_cfg(); c.pen = 1'b1; c.sp = 1'b1; c.eps = 1'b1; cfgq.push_back(c);
        c = rand_cfg(); c.pen = 1'b1; c.sp = 1'b1; c.eps = 1'b0; cfgq.push_back(c);
        do_frames(-1);

        // break during the first data bit (a 1)
        bdiv = 3;
        cfgq.push_back('{din: 8'h13, wls: 2'b11, pen: 1'b1, eps: 1'b1, sp: 1'b0, stb: 1'b0});
        cfgq.push_back(rand_cfg());
        do_frames(1);

        // randomized chains
        for (int r = 0; r < 3; r++) begin
            bdiv = $urandom_range(1, 4);
            for (int i = 0; i < 3; i++) cfgq.push_back(rand_cfg());
            do_frames(-1);
        end

        // reset in the middle of a data bit
        bdiv = 2;
        @(negedge clk);
        drive_cfg('{din: 8'h00, wls: 2'b11, pen: 1'b0, eps: 1'b0, sp: 1'b0, stb: 1'b0});
        thre = 1'b0;
        wait_pop(200);
        thre = 1'b1;
        wait_ticks(16 + 32 + 8);
        chk("pre_rst_tx", {31'd0, tx}, 32'd0);
        base = pop_cnt;
        #2 rst = 1'b0;
        #1;
        chk("midrst_tx", {31'd0, tx}, 32'd1);
        chk("midrst_empty", {31'd0, sreg_empty}, 32'd1);
        chk("midrst_pop", {31'd0, pop}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        wait_ticks(20);
        chk("postrst_tx", {31'd0, tx}, 32'd1);
        chk("postrst_empty", {31'd0, sreg_empty}, 32'd1);
        chk("postrst_pops", pop_cnt - base, 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
`default_nettype wire
